// File: rtl/shift_sequencer.sv
// ============================================================================
// shift_sequencer : round-robin command sequencer driving an external 8-bit USR
// Optional SHSEQ_STATS_EN adds cmd_cnt / last_id_busy_cycles. Rev 1.0
// ============================================================================
`default_nettype none

module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_mode,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_mode,
  input  logic [AMT_W-1:0] req1_amt,
  input  logic [WIDTH-1:0] req1_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic [1:0]       usr_ctrl,
  output logic [WIDTH-1:0] usr_d,
  input  logic [WIDTH-1:0] usr_y,
`ifdef SHSEQ_STATS_EN
  output logic [15:0]      cmd_cnt,
  output logic [7:0]       last_id_busy_cycles,
`endif
  output logic             busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_CAPT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             rr_q, rr_d;
  logic [1:0]       mode_q, mode_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_id_q, rsp_id_d;

  logic             w_idle, w_grant0, w_grant1, w_accept, w_first;
  logic [1:0]       w_sel_mode;
  logic [AMT_W-1:0] w_sel_amt;
  logic [WIDTH-1:0] w_sel_data;

  // rr_q == 0 gives req0 priority when both requesters are valid
  assign w_idle   = (state_q == ST_IDLE);
  assign w_grant0 = req0_valid & (~req1_valid | ~rr_q);
  assign w_grant1 = req1_valid & (~req0_valid | rr_q);

  assign req0_ready = w_idle & w_grant0 & ~rst;
  assign req1_ready = w_idle & w_grant1 & ~rst;
  assign w_accept   = req0_ready | req1_ready;

  assign w_sel_mode = w_grant1 ? req1_mode : req0_mode;
  assign w_sel_amt  = w_grant1 ? req1_amt  : req0_amt;
  assign w_sel_data = w_grant1 ? req1_data : req0_data;

  // Counter still equal to the latched amount marks the first SHIFT cycle
  assign w_first  = (cnt_q == amt_q);
  assign usr_ctrl = (state_q == ST_SHIFT) ? mode_q : 2'b00;
  assign usr_d    = (state_q == ST_SHIFT) ? (w_first ? data_q : usr_y) : '0;

  assign busy      = ~w_idle;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    mode_d      = mode_q;
    amt_d       = amt_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          mode_d = w_sel_mode;
          amt_d  = w_sel_amt;
          data_d = w_sel_data;
          id_d   = w_grant1;
          rr_d   = ~w_grant1;
          if (w_sel_amt == '0) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = w_sel_data;
            rsp_id_d    = w_grant1;
            state_d     = ST_RESP;
          end else begin
            cnt_d   = w_sel_amt;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == AMT_W'(1)) state_d = ST_CAPT;
      end
      ST_CAPT: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = usr_y;
        rsp_id_d    = id_q;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_q        <= 1'b0;
      mode_q      <= 2'b00;
      amt_q       <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      mode_q      <= mode_d;
      amt_q       <= amt_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

`ifdef SHSEQ_STATS_EN
  logic [15:0] cmd_cnt_q;
  logic [7:0]  last_busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_cnt_q   <= 16'h0000;
      last_busy_q <= 8'h00;
    end else if (rsp_valid_q & rsp_ready) begin
      if (cmd_cnt_q != 16'hFFFF) cmd_cnt_q <= cmd_cnt_q + 16'h0001;
      last_busy_q <= 8'(amt_q);
    end
  end

  assign cmd_cnt             = cmd_cnt_q;
  assign last_id_busy_cycles = last_busy_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_shift_sequencer.sv
// ============================================================================
// tb_shift_sequencer : directed + random checks of shift_sequencer against a
// command-level reference model and a behavioural USR. Rev 1.0
// ============================================================================
`default_nettype none

module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [1:0] req0_mode = 2'b00, req1_mode = 2'b00;
  logic [2:0] req0_amt = 3'd0, req1_amt = 3'd0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       rsp_valid, rsp_id;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic [1:0] usr_ctrl;
  logic [7:0] usr_d;
  logic [7:0] usr_y = 8'h00;
  logic       busy;
`ifdef SHSEQ_STATS_EN
  logic [15:0] cmd_cnt;
  logic [7:0]  last_id_busy_cycles;
`endif

  int n_vec = 0;
  int n_err = 0;

  shift_sequencer #(.WIDTH(8), .AMT_W(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
    .req0_amt(req0_amt), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
    .req1_amt(req1_amt), .req1_data(req1_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .usr_ctrl(usr_ctrl), .usr_d(usr_d), .usr_y(usr_y),
`ifdef SHSEQ_STATS_EN
    .cmd_cnt(cmd_cnt), .last_id_busy_cycles(last_id_busy_cycles),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] usr_f(input logic [1:0] c, input logic [7:0] d);
    case (c)
      2'b00:   return d >> 1;
      2'b01:   return d << 1;
      2'b10:   return {d[0], d[7:1]};
      default: return {d[6:0], d[7]};
    endcase
  endfunction

  // Behavioural USR: registers f(ctrl, d) on every edge
  always @(posedge clk) usr_y <= usr_f(usr_ctrl, usr_d);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Command-level model: m_left counts edges remaining until the result loads
  bit       m_busy = 0, m_rr = 0, m_id = 0;
  bit       m_rsp_valid = 0, m_rsp_id = 0;
  bit [1:0] m_mode = 0;
  int       m_amt = 0, m_left = 0;
  bit [7:0] m_cur = 0, m_rsp_data = 0;
  int       m_cnt = 0, m_last = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_rr = 0; m_id = 0; m_rsp_valid = 0; m_rsp_id = 0;
      m_mode = 0; m_amt = 0; m_left = 0; m_cur = 0; m_rsp_data = 0;
      m_cnt = 0; m_last = 0;
    end else if (!m_busy) begin
      bit g0, g1;
      g0 = req0_valid && (!req1_valid || !m_rr);
      g1 = req1_valid && (!req0_valid || m_rr);
      if (g0 || g1) begin
        m_id   = g1;
        m_rr   = !g1;
        m_mode = g1 ? req1_mode : req0_mode;
        m_amt  = g1 ? int'(req1_amt) : int'(req0_amt);
        m_cur  = g1 ? req1_data : req0_data;
        m_busy = 1;
        if (m_amt == 0) begin
          m_rsp_valid = 1; m_rsp_data = m_cur; m_rsp_id = m_id; m_left = 0;
        end else begin
          m_left = m_amt + 1;
        end
      end
    end else if (m_rsp_valid) begin
      if (rsp_ready) begin
        m_rsp_valid = 0; m_busy = 0;
        if (m_cnt < 65535) m_cnt++;
        m_last = m_amt;
      end
    end else begin
      if (m_left >= 2) m_cur = usr_f(m_mode, m_cur);
      m_left--;
      if (m_left == 0) begin
        m_rsp_valid = 1; m_rsp_data = m_cur; m_rsp_id = m_id;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_usr_ctrl", usr_ctrl, 0);
      chk("rst_usr_d", usr_d, 0);
    end else begin
      bit g0, g1, sh;
      g0 = req0_valid && (!req1_valid || !m_rr);
      g1 = req1_valid && (!req0_valid || m_rr);
      sh = m_busy && !m_rsp_valid && (m_left >= 2);
      chk("req0_ready", req0_ready, !m_busy && g0);
      chk("req1_ready", req1_ready, !m_busy && g1);
      chk("busy", busy, m_busy);
      chk("rsp_valid", rsp_valid, m_rsp_valid);
      chk("rsp_data", rsp_data, m_rsp_data);
      chk("rsp_id", rsp_id, m_rsp_id);
      chk("usr_ctrl", usr_ctrl, sh ? m_mode : 2'b00);
      chk("usr_d", usr_d, sh ? m_cur : 8'h00);
`ifdef SHSEQ_STATS_EN
      chk("cmd_cnt", cmd_cnt, m_cnt);
      chk("last_id_busy_cycles", last_id_busy_cycles, m_last);
`endif
    end
  end

  // Issue one command, check literal result/latency, optionally stall rsp_ready
  task automatic run_cmd(input bit id, input logic [1:0] mode, input logic [2:0] amt,
                         input logic [7:0] data, input logic [7:0] exp, input int hold);
    bit ok;
    int k, nctrl;
    rsp_ready = (hold == 0);
    if (id) begin req1_valid = 1; req1_mode = mode; req1_amt = amt; req1_data = data; end
    else    begin req0_valid = 1; req0_mode = mode; req0_amt = amt; req0_data = data; end
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin chk("accept_timeout", 0, 1); req0_valid = 0; req1_valid = 0; return; end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    k = 0; nctrl = 0; ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (usr_ctrl != 2'b00) nctrl++;
      if (rsp_valid) begin ok = 1; break; end
      @(posedge clk); #1;
      k++;
    end
    chk("rsp_timeout", ok, 1);
    chk("latency", k, (amt == 0) ? 0 : amt + 1);
    chk("shift_cycles", nctrl, (mode != 2'b00) ? amt : 0);
    chk("lit_rsp_data", rsp_data, exp);
    chk("lit_rsp_id", rsp_id, id);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_rsp_data", rsp_data, exp);
      chk("hold_rsp_id", rsp_id, id);
      chk("hold_busy", busy, 1);
      chk("hold_readies", {req0_ready, req1_ready}, 0);
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    chk("hs_rsp_valid", rsp_valid, 0);
    chk("hs_busy", busy, 0);
  endtask

  task automatic drain();
    bit ok;
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    chk("drain_idle", ok, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int acc, last_cyc;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;

    run_cmd(0, 2'b10, 3'd3, 8'h81, 8'h30, 0);
    run_cmd(1, 2'b01, 3'd7, 8'hFF, 8'h80, 0);
    run_cmd(0, 2'b00, 3'd2, 8'hF0, 8'h3C, 0);
    run_cmd(0, 2'b11, 3'd1, 8'h81, 8'h03, 0);
    run_cmd(0, 2'b00, 3'd0, 8'hA5, 8'hA5, 0);
    run_cmd(1, 2'b11, 3'd2, 8'h0F, 8'h3C, 5);

    // Reset in the middle of a shift, with both requesters pending
    req0_valid = 1; req0_mode = 2'b10; req0_amt = 3'd5; req0_data = 8'h5A;
    @(negedge clk);
    chk("t6_accept_ready", req0_ready, 1);
    @(posedge clk); #1;
    req1_valid = 1; req1_mode = 2'b11; req1_amt = 3'd1; req1_data = 8'h11;
    req0_mode = 2'b01; req0_amt = 3'd1; req0_data = 8'h22;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6_pre_rst_ctrl", usr_ctrl, 2'b10);
    #1 rst = 1;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_usr_ctrl", usr_ctrl, 0);
    chk("t6_rst_usr_d", usr_d, 0);
    chk("t6_rst_readies", {req0_ready, req1_ready}, 0);
    chk("t6_rst_rsp", {rsp_valid, rsp_id, rsp_data}, 0);
`ifdef SHSEQ_STATS_EN
    chk("t6_rst_cmd_cnt", cmd_cnt, 0);
`endif
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("t6_first_grant", {req0_ready, req1_ready}, 2'b10);

    // Both requesters saturating with amt=1: strict alternation
    rsp_ready = 1;
    acc = 0; last_cyc = -100;
    for (int c = 0; c < 80 && acc < 8; c++) begin
      if (req0_ready || req1_ready) begin
        chk("t4_rr_id", req1_ready, acc % 2);
        chk("t4_gap_ge4", (c - last_cyc) >= 4, 1);
        last_cyc = c;
        acc++;
      end
      @(posedge clk); #1;
      @(negedge clk);
    end
    chk("t4_accepts", acc, 8);
    @(posedge clk); #1;
    drain();

    for (int c = 0; c < 2500; c++) begin
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_mode = 2'($urandom); req0_amt = 3'($urandom); req0_data = 8'($urandom);
      req1_mode = 2'($urandom); req1_amt = 3'($urandom); req1_data = 8'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
